// File: rtl/matrix_pattern_gen.sv
// matrix_pattern_gen: Wishbone master that renders RGB565 test patterns into a double-buffered LED framebuffer
// Ports: clk/rst (async, active-high); adr_o/dat_o/dat_i/we_o/sel_o/stb_o/cyc_o/ack_i/cti_o classic Wishbone master;
// enable_i gates frame triggers, mode_i picks the pattern; busy_o spans a frame; frame_done_o/timeout_o/overrun_o are 1-cycle pulses.
module matrix_pattern_gen #(
  parameter int ADDRESS_WIDTH = 16,
  parameter int DATA_WIDTH = 16,
  parameter int COLS = 20,
  parameter int ROWS = 15,
  parameter int ROW_STRIDE = 32,
  parameter int FRAME_ADDRESS = 'h0000,
  parameter int PAGE_STRIDE = 'h0400,
  parameter int CTRL_ADDRESS = 'h4000,
  parameter int FRAME_TIME = 2400000,
  parameter int FRAME_DELAY_START = 100,
  parameter int MAX_WAIT = 8
) (
  input  logic                      clk,
  input  logic                      rst,
  output logic [ADDRESS_WIDTH-1:0]  adr_o,
  output logic [DATA_WIDTH-1:0]     dat_o,
  input  logic [DATA_WIDTH-1:0]     dat_i,
  output logic                      we_o,
  output logic [DATA_WIDTH/8-1:0]   sel_o,
  output logic                      stb_o,
  output logic                      cyc_o,
  input  logic                      ack_i,
  output logic [2:0]                cti_o,
  input  logic                      enable_i,
  input  logic [1:0]                mode_i,
  output logic                      busy_o,
  output logic                      frame_done_o,
  output logic                      timeout_o,
  output logic                      overrun_o
);
  localparam int AW = ADDRESS_WIDTH;
  localparam int DW = DATA_WIDTH;
  localparam int CW = COLS > 1 ? $clog2(COLS) : 1;
  localparam int RW = ROWS > 1 ? $clog2(ROWS) : 1;
  localparam int WW = $clog2(MAX_WAIT + 1);
  localparam int TW = $clog2((FRAME_TIME > FRAME_DELAY_START ? FRAME_TIME : FRAME_DELAY_START) + 1);
  typedef enum logic [2:0] {WAIT, COMPUTE, BUS, FLIP_SETUP, FLIP_BUS} state_t;
  state_t state_q;
  logic [TW-1:0] timer_q;
  logic [RW-1:0] row_q;
  logic [CW-1:0] col_q;
  logic [1:0] mode_q;
  logic [4:0] offset_q;
  logic [WW-1:0] wait_q;
  logic [AW-1:0] adr_q;
  logic [DW-1:0] dat_q;
  logic page_q, cyc_q, busy_q, frame_done_q, timeout_q, overrun_q;
  logic trig, start, timed_out, last_col, last_pix, unused_dat;
  logic [CW-1:0] col_r_d, c_d;
  logic [15:0] sum_d, pix_d, flip_d;
  logic [2:0] idx_d;
  logic [AW-1:0] base_d, pix_adr_d;
  function automatic logic [15:0] palette(input logic [2:0] i);
    return i == 3'd0 ? 16'hF800 : i == 3'd1 ? 16'hF300 : i == 3'd2 ? 16'hF5E0 :
           i == 3'd3 ? 16'h07C0 : i == 3'd4 ? 16'h001F : i == 3'd5 ? 16'h7817 : 16'h0000;
  endfunction
  assign trig = timer_q == '0;
  // A trigger landing in the frame_done_o cycle belongs to the finished frame and is treated as overrun
  assign start = trig && enable_i && state_q == WAIT && !frame_done_q;
  assign timed_out = wait_q == WW'(MAX_WAIT - 1);
  assign last_col = col_q == CW'(COLS - 1);
  assign last_pix = last_col && row_q == RW'(ROWS - 1);
  assign col_r_d = CW'(COLS - 1) - col_q;
  assign c_d = (mode_q == 2'd1 && col_r_d < col_q) ? col_r_d : col_q;
  assign sum_d = 16'(offset_q) + 16'(row_q) + 16'(c_d);
  assign idx_d = 3'((sum_d % 16'd24) / 16'd4);
  assign pix_d = mode_q == 2'd2 ? ((row_q[0] ^ col_q[0] ^ offset_q[1]) ? 16'h0000 : 16'hFFFF)
               : palette(mode_q == 2'd3 ? offset_q[4:2] : idx_d);
  assign base_d = AW'(FRAME_ADDRESS) + (page_q ? AW'(PAGE_STRIDE) : AW'(0));
  assign pix_adr_d = base_d + AW'(row_q) * AW'(ROW_STRIDE) + AW'(col_q);
  assign flip_d = 16'({base_d, 1'b0});
  assign unused_dat = ^dat_i;
  assign adr_o = adr_q;
  assign dat_o = dat_q;
  assign cyc_o = cyc_q;
  assign stb_o = cyc_q;
  assign we_o = cyc_q;
  assign sel_o = '1;
  assign cti_o = 3'b000;
  assign busy_o = busy_q;
  assign frame_done_o = frame_done_q;
  assign timeout_o = timeout_q;
  assign overrun_o = overrun_q;
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= WAIT;
      timer_q <= TW'(FRAME_DELAY_START);
      row_q <= '0;
      col_q <= '0;
      mode_q <= '0;
      offset_q <= '0;
      wait_q <= '0;
      adr_q <= '0;
      dat_q <= '0;
      page_q <= 1'b0;
      cyc_q <= 1'b0;
      busy_q <= 1'b0;
      frame_done_q <= 1'b0;
      timeout_q <= 1'b0;
      overrun_q <= 1'b0;
    end else begin
      timer_q <= trig ? TW'(FRAME_TIME - 1) : timer_q - TW'(1);
      frame_done_q <= 1'b0;
      timeout_q <= 1'b0;
      overrun_q <= trig && (state_q != WAIT || frame_done_q);
      case (state_q)
        WAIT: begin
          row_q <= '0;
          col_q <= '0;
          if (start) begin
            mode_q <= mode_i;
            busy_q <= 1'b1;
            state_q <= COMPUTE;
          end
        end
        COMPUTE: begin
          adr_q <= pix_adr_d;
          dat_q <= DW'(pix_d);
          cyc_q <= 1'b1;
          wait_q <= '0;
          state_q <= BUS;
        end
        BUS: begin
          if (ack_i) begin
            cyc_q <= 1'b0;
            col_q <= last_col ? '0 : col_q + CW'(1);
            row_q <= last_col ? row_q + RW'(1) : row_q;
            state_q <= last_pix ? FLIP_SETUP : COMPUTE;
          end else if (timed_out) begin
            cyc_q <= 1'b0;
            timeout_q <= 1'b1;
            state_q <= COMPUTE;
          end else begin
            wait_q <= wait_q + WW'(1);
          end
        end
        FLIP_SETUP: begin
          adr_q <= AW'(CTRL_ADDRESS);
          dat_q <= DW'(flip_d);
          cyc_q <= 1'b1;
          wait_q <= '0;
          state_q <= FLIP_BUS;
        end
        FLIP_BUS: begin
          if (ack_i) begin
            cyc_q <= 1'b0;
            page_q <= ~page_q;
            offset_q <= offset_q >= 5'd22 ? 5'd0 : offset_q + 5'd2;
            frame_done_q <= 1'b1;
            busy_q <= 1'b0;
            state_q <= WAIT;
          end else if (timed_out) begin
            cyc_q <= 1'b0;
            timeout_q <= 1'b1;
            state_q <= FLIP_SETUP;
          end else begin
            wait_q <= wait_q + WW'(1);
          end
        end
        default: state_q <= WAIT;
      endcase
    end
  end
endmodule

// File: tb/tb_matrix_pattern_gen.sv
// tb_matrix_pattern_gen: randomized self-checking bench for matrix_pattern_gen against a pattern reference model
module tb_matrix_pattern_gen;
  localparam int FT = 200;
  localparam int NW = 301;
  logic clk = 1'b0, rst = 1'b1;
  logic [15:0] adr_o, dat_o, dat_i;
  logic [1:0] sel_o, mode_i;
  logic [2:0] cti_o;
  logic we_o, stb_o, cyc_o, ack_i, enable_i, busy_o, frame_done_o, timeout_o, overrun_o;
  logic no_ack = 1'b0, rand_lat = 1'b0;
  int lat_r = 0, wcnt = 0, cyc_n = 0;
  int n_cmp = 0, n_err = 0;
  logic [15:0] wa_q[$], wd_q[$];
  int br_q[$], fd_q[$];
  int n_to = 0, n_ov = 0, n_cyc = 0;
  logic busy_p = 1'b0;
  always #5 clk = ~clk;
  assign dat_i = 16'h0;
  assign ack_i = cyc_o & stb_o & ~no_ack & (wcnt >= (rand_lat ? lat_r : 0));
  matrix_pattern_gen #(.FRAME_TIME(FT), .FRAME_DELAY_START(100)) dut (
    .clk(clk), .rst(rst), .adr_o(adr_o), .dat_o(dat_o), .dat_i(dat_i), .we_o(we_o), .sel_o(sel_o),
    .stb_o(stb_o), .cyc_o(cyc_o), .ack_i(ack_i), .cti_o(cti_o), .enable_i(enable_i), .mode_i(mode_i),
    .busy_o(busy_o), .frame_done_o(frame_done_o), .timeout_o(timeout_o), .overrun_o(overrun_o));
  always @(posedge clk) begin
    wcnt <= (!(cyc_o && stb_o) || ack_i) ? 0 : wcnt + 1;
    if (ack_i) lat_r <= $urandom_range(0, 2);
  end
  always @(posedge clk or posedge rst) cyc_n <= rst ? 0 : cyc_n + 1;
  always @(negedge clk) begin
    if (rst) begin
      wa_q.delete(); wd_q.delete(); br_q.delete(); fd_q.delete();
      n_to <= 0; n_ov <= 0; n_cyc <= 0; busy_p <= 1'b0;
    end else begin
      if (cyc_o && stb_o && we_o && ack_i) begin
        wa_q.push_back(adr_o);
        wd_q.push_back(dat_o);
      end
      if (timeout_o) n_to <= n_to + 1;
      if (overrun_o) n_ov <= n_ov + 1;
      if (cyc_o) n_cyc <= n_cyc + 1;
      if (frame_done_o) fd_q.push_back(cyc_n);
      if (busy_o && !busy_p) br_q.push_back(cyc_n);
      busy_p <= busy_o;
    end
  end
  function automatic logic [15:0] pal(input int i);
    case (i)
      0: return 16'hF800;
      1: return 16'hF300;
      2: return 16'hF5E0;
      3: return 16'h07C0;
      4: return 16'h001F;
      5: return 16'h7817;
      default: return 16'h0000;
    endcase
  endfunction
  function automatic logic [15:0] pix(input int m, input int r, input int c, input int off);
    int cc;
    cc = (m == 1 && 19 - c < c) ? 19 - c : c;
    if (m == 2) return ((r + c + ((off >> 1) & 1)) % 2 == 0) ? 16'hFFFF : 16'h0000;
    if (m == 3) return pal(off / 4);
    return pal(((off + r + cc) % 24) / 4);
  endfunction
  // write k of frame f (frames counted from reset): 300 pixels then the flip write
  function automatic logic [15:0] exp_adr(input int f, input int k);
    if (k == 300) return 16'h4000;
    return 16'((f % 2) * 'h400 + (k / 20) * 32 + k % 20);
  endfunction
  function automatic logic [15:0] exp_dat(input int f, input int m, input int k);
    if (k == 300) return 16'((f % 2) * 'h800);
    return pix(m, k / 20, k % 20, (2 * f) % 24);
  endfunction
  task automatic do_reset(input logic en);
    rst = 1'b1;
    enable_i = en;
    mode_i = 2'd0;
    no_ack = 1'b0;
    rand_lat = 1'b0;
    repeat (2) @(negedge clk);
    rst = 1'b0;
  endtask
  task automatic wait_fd(input int n, input int budget, output bit ok);
    for (int i = 0; i < budget && fd_q.size() < n; i++) @(negedge clk);
    @(negedge clk);
    ok = fd_q.size() >= n;
  endtask
  task automatic test_reset;
    rst = 1'b1;
    enable_i = 1'b1;
    mode_i = 2'd0;
    repeat (3) @(negedge clk);
    n_cmp++;
    if ({adr_o, dat_o, cyc_o, stb_o, we_o, busy_o, frame_done_o, timeout_o, overrun_o, cti_o} !== '0) begin
      n_err++;
      $display("FAIL reset_outputs: adr=%h dat=%h cyc=%b stb=%b we=%b busy=%b pulses=%b%b%b cti=%b, all required 0",
               adr_o, dat_o, cyc_o, stb_o, we_o, busy_o, frame_done_o, timeout_o, overrun_o, cti_o);
    end
    n_cmp++;
    if (sel_o !== 2'b11) begin n_err++; $display("FAIL reset_sel: got %b expected 11", sel_o); end
  endtask
  task automatic test_first_frames;
    bit ok;
    do_reset(1'b1);
    wait_fd(2, 2000, ok);
    n_cmp++;
    if (!ok) begin n_err++; $display("FAIL two_frames_done: got %0d frames expected 2", fd_q.size()); end
    n_cmp++;
    if ((br_q.size() > 0 ? br_q[0] : -1) != 101) begin
      n_err++; $display("FAIL first_busy_rise: got %0d expected 101", br_q.size() > 0 ? br_q[0] : -1);
    end
    n_cmp++;
    if ((fd_q.size() > 0 && br_q.size() > 0 ? fd_q[0] - br_q[0] : -1) != 602) begin
      n_err++; $display("FAIL frame_length: got %0d expected 602", fd_q.size() > 0 && br_q.size() > 0 ? fd_q[0] - br_q[0] : -1);
    end
    n_cmp++;
    if ((br_q.size() > 1 ? br_q[1] : -1) != 901) begin
      n_err++; $display("FAIL second_busy_rise: got %0d expected 901", br_q.size() > 1 ? br_q[1] : -1);
    end
    // triggers at 300,500,700 and 1100,1300,1500 all land while a frame is in flight
    n_cmp++;
    if (n_ov != 6) begin n_err++; $display("FAIL overrun_count: got %0d expected 6", n_ov); end
    n_cmp++;
    if (wa_q.size() != 2 * NW) begin n_err++; $display("FAIL write_count: got %0d expected %0d", wa_q.size(), 2 * NW); end
    for (int k = 0; k < 2 * NW && k < wa_q.size(); k++) begin
      n_cmp++;
      if (wa_q[k] !== exp_adr(k / NW, k % NW) || wd_q[k] !== exp_dat(k / NW, 0, k % NW)) begin
        n_err++;
        $display("FAIL frame_write[%0d]: got %h/%h expected %h/%h", k, wa_q[k], wd_q[k], exp_adr(k / NW, k % NW), exp_dat(k / NW, 0, k % NW));
      end
    end
  endtask
  task automatic test_timeout;
    bit ok, seen;
    int hi;
    hi = 0;
    seen = 0;
    do_reset(1'b1);
    no_ack = 1'b1;
    for (int i = 0; i < 300 && !seen; i++) begin
      @(negedge clk);
      if (timeout_o) begin
        seen = 1;
        n_cmp++;
        if (cyc_o !== 1'b0 || stb_o !== 1'b0) begin n_err++; $display("FAIL timeout_drop: cyc=%b stb=%b expected 0", cyc_o, stb_o); end
      end else if (cyc_o) hi++;
    end
    n_cmp++;
    if (!seen || hi != 8) begin n_err++; $display("FAIL timeout_wait: seen=%0d cycles=%0d expected 8", seen, hi); end
    no_ack = 1'b0;
    @(negedge clk);
    n_cmp++;
    if (cyc_o !== 1'b1 || adr_o !== 16'h0000) begin n_err++; $display("FAIL retry: cyc=%b adr=%h expected 1/0000", cyc_o, adr_o); end
    wait_fd(1, 1000, ok);
    n_cmp++;
    if (!ok || n_to != 1 || wa_q.size() != NW) begin
      n_err++; $display("FAIL timeout_frame: done=%0d timeouts=%0d writes=%0d expected 1/1/%0d", ok, n_to, wa_q.size(), NW);
    end
    for (int k = 0; k < NW && k < wa_q.size(); k++) begin
      n_cmp++;
      if (wa_q[k] !== exp_adr(0, k) || wd_q[k] !== exp_dat(0, 0, k)) begin
        n_err++; $display("FAIL retry_write[%0d]: got %h/%h expected %h/%h", k, wa_q[k], wd_q[k], exp_adr(0, k), exp_dat(0, 0, k));
      end
    end
  endtask
  task automatic test_enable;
    bit ok;
    do_reset(1'b0);
    repeat (350) @(negedge clk);
    n_cmp++;
    if (n_cyc != 0 || br_q.size() != 0 || n_ov != 0) begin
      n_err++; $display("FAIL disabled_idle: cyc_cycles=%0d frames=%0d overruns=%0d expected 0/0/0", n_cyc, br_q.size(), n_ov);
    end
    enable_i = 1'b1;
    for (int i = 0; i < 300 && br_q.size() == 0; i++) @(negedge clk);
    @(negedge clk);
    n_cmp++;
    if ((br_q.size() > 0 ? br_q[0] : -1) != 501) begin
      n_err++; $display("FAIL enable_start: got %0d expected 501", br_q.size() > 0 ? br_q[0] : -1);
    end
    enable_i = 1'b0;
    wait_fd(1, 1000, ok);
    n_cmp++;
    if (!ok || wa_q.size() != NW) begin n_err++; $display("FAIL enable_drop_midframe: done=%0d writes=%0d expected 1/%0d", ok, wa_q.size(), NW); end
    repeat (400) @(negedge clk);
    n_cmp++;
    if (fd_q.size() != 1 || br_q.size() != 1) begin
      n_err++; $display("FAIL disabled_after: frames=%0d starts=%0d expected 1/1", fd_q.size(), br_q.size());
    end
  endtask
  task automatic test_random_modes;
    int plan[3];
    int nf;
    plan[0] = 1;
    plan[1] = $urandom_range(0, 3);
    plan[2] = $urandom_range(0, 3);
    do_reset(1'b1);
    rand_lat = 1'b1;
    // mode_i and enable_i are scrambled while busy; only the values held in WAIT matter
    for (int i = 0; i < 8000 && fd_q.size() < 3; i++) begin
      @(negedge clk);
      nf = fd_q.size() > 2 ? 2 : fd_q.size();
      mode_i = busy_o ? 2'($urandom) : 2'(plan[nf]);
      enable_i = busy_o ? 1'($urandom) : 1'b1;
    end
    @(negedge clk);
    n_cmp++;
    if (fd_q.size() < 3 || n_to != 0) begin n_err++; $display("FAIL random_frames: frames=%0d timeouts=%0d expected 3/0", fd_q.size(), n_to); end
    n_cmp++;
    if (wd_q.size() < 20 || wd_q[19] !== 16'hF800) begin n_err++; $display("FAIL mirror_edge: got %h expected f800", wd_q.size() < 20 ? 16'hxxxx : wd_q[19]); end
    for (int k = 0; k < 3 * NW && k < wa_q.size(); k++) begin
      n_cmp++;
      if (wa_q[k] !== exp_adr(k / NW, k % NW) || wd_q[k] !== exp_dat(k / NW, plan[k / NW], k % NW)) begin
        n_err++;
        $display("FAIL random_write[%0d] mode %0d: got %h/%h expected %h/%h", k, plan[k / NW], wa_q[k], wd_q[k],
                 exp_adr(k / NW, k % NW), exp_dat(k / NW, plan[k / NW], k % NW));
      end
    end
    rand_lat = 1'b0;
  endtask
  task automatic test_reset_mid_bus;
    bit ok;
    do_reset(1'b1);
    no_ack = 1'b1;
    for (int i = 0; i < 300 && !cyc_o; i++) @(negedge clk);
    #2 rst = 1'b1;
    #1;
    n_cmp++;
    if (cyc_o !== 1'b0 || stb_o !== 1'b0 || busy_o !== 1'b0) begin
      n_err++; $display("FAIL async_reset: cyc=%b stb=%b busy=%b expected 0", cyc_o, stb_o, busy_o);
    end
    no_ack = 1'b0;
    repeat (2) @(negedge clk);
    rst = 1'b0;
    wait_fd(1, 1000, ok);
    n_cmp++;
    if (!ok || wa_q.size() != NW || wa_q[0] !== 16'h0000 || wd_q[0] !== 16'hF800 || wd_q[300] !== 16'h0000) begin
      n_err++; $display("FAIL after_reset_frame: done=%0d writes=%0d first=%h/%h flip=%h expected 1/301/0000/f800/0000",
                        ok, wa_q.size(), wa_q.size() > 0 ? wa_q[0] : 16'hxxxx, wd_q.size() > 0 ? wd_q[0] : 16'hxxxx,
                        wd_q.size() > 300 ? wd_q[300] : 16'hxxxx);
    end
  endtask
  initial begin
    enable_i = 1'b0;
    mode_i = 2'd0;
    test_reset;
    test_first_frames;
    test_timeout;
    test_enable;
    test_random_modes;
    test_reset_mid_bus;
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule

// File: doc/matrix_pattern_gen.md
# matrix_pattern_gen

Parametrised Wishbone-master pattern generator that renders one of four RGB565 test patterns into a double-buffered LED-matrix framebuffer once per frame period. After each rendered frame it writes the new page base to the matrix controller's frame-pointer register. It sits on the shared Wishbone bus beside the CPU and matrix driver, and is used for bring-up, burn-in and idle animation.

## Interface
- ADDRESS_WIDTH, 16, Wishbone address width
- DATA_WIDTH, 16, Wishbone data width; must be ≥16, and bits above 15 are driven 0
- COLS, 20, pixels per row
- ROWS, 15, rows per frame
- ROW_STRIDE, 32, address step between rows
- FRAME_ADDRESS, 16'h0000, base address of page 0
- PAGE_STRIDE, 16'h0400, address offset of page 1
- CTRL_ADDRESS, 16'h4000, address of the matrix frame-pointer register
- FRAME_TIME, 2400000, clocks between frame triggers
- FRAME_DELAY_START, 100, clocks from reset to the first trigger
- MAX_WAIT, 8, bus cycles to wait for ack before timeout
- clk  in  1  clock
- rst  in  1  reset, asynchronous, active-high
- adr_o  out  ADDRESS_WIDTH  Wishbone address
- dat_o  out  DATA_WIDTH  write data
- dat_i  in  DATA_WIDTH  unused; read data is ignored
- we_o  out  1  write enable
- sel_o  out  DATA_WIDTH/8  byte selects, constant all-ones
- stb_o  out  1  strobe
- cyc_o  out  1  cycle
- ack_i  in  1  acknowledge
- cti_o  out  3  constant 3'b000 (classic cycle)
- enable_i  in  1  allows frame triggers to start frames
- mode_i  in  2  pattern select, sampled at frame start
- busy_o  out  1  high from frame start until the flip write completes
- frame_done_o  out  1  one-cycle pulse when the flip write is acked
- timeout_o  out  1  one-cycle pulse on each bus timeout
- overrun_o  out  1  one-cycle pulse when a trigger arrives while busy

## Operation
- **Frame timer**
  - Counter loads FRAME_DELAY_START on reset and decrements each clock.
  - At 0 it emits a one-cycle trigger and reloads FRAME_TIME.
  - The timer runs regardless of enable_i.
- **States:** WAIT, COMPUTE, BUS, FLIP_SETUP, FLIP_BUS.
- **WAIT**
  - row=col=0.
  - On a trigger with enable_i=1, latch mode_i and go to COMPUTE.
  - A trigger with enable_i=0 is ignored.
- **COMPUTE** (1 cycle)
  - Register adr_o = FRAME_ADDRESS + (page ? PAGE_STRIDE : 0) + row*ROW_STRIDE + col, modulo 2^ADDRESS_WIDTH.
  - Register dat_o from the pattern, then go to BUS.
- **Colour index** ci (5 bits) = (offset + row + c) mod 24.
  - c = col in mode 0.
  - c = min(col, COLS-1-col) in mode 1 (mirrored).
- **Palette** by ci[4:2]:
  - 0: F800
  - 1: F300
  - 2: F5E0
  - 3: 07C0
  - 4: 001F
  - 5: 7817
- **Mode 2:** checkerboard. Pixel is FFFF when (row+col+offset[1]) is even, else 0000.
- **Mode 3:** solid palette[offset[4:2]].
- **BUS**
  - cyc_o=stb_o=we_o=1 until ack_i.
  - On ack, advance: col+1. At col=COLS-1, col←0 and row+1. At the last pixel, go to FLIP_SETUP; otherwise go to COMPUTE.
- **Timeout:** if no ack after MAX_WAIT BUS cycles:
  - drop cyc/stb for one cycle;
  - pulse timeout_o;
  - retry the same pixel via COMPUTE.
- **FLIP_SETUP**
  - adr_o = CTRL_ADDRESS.
  - dat_o = {(FRAME_ADDRESS + (page ? PAGE_STRIDE : 0)), 1'b0}, truncated to DATA_WIDTH.
- **FLIP_BUS**
  - Same handshake as BUS.
  - On ack: page ← ~page; offset ← (offset ≥ 22) ? 0 : offset+2; pulse frame_done_o; return to WAIT.
  - On timeout: pulse timeout_o and retry.
- **Mid-frame changes:** enable_i falling or mode_i changing mid-frame has no effect until the next frame.
- **Overrun:** a trigger while not in WAIT pulses overrun_o and is discarded.

## Timing
- **Reset values:** adr_o=0, dat_o=0, cyc_o=stb_o=we_o=0, busy_o=0, all pulses 0, page=0, offset=0, state WAIT.
- **Reset mid-cycle:** cyc_o/stb_o drop asynchronously.
- **Frame start:** busy_o rises the cycle after the accepted trigger.
- **Pixel timing:** cyc_o rises 1 cycle after COMPUTE entry.
- **Zero-wait slave:** ack in the first BUS cycle gives 2 clocks per pixel.
- **Frame length:** zero-wait frame = 2·ROWS·COLS + 2 clocks from busy_o rise to the frame_done_o cycle.
- **Bus outputs:** adr_o/dat_o are stable for the whole cyc_o high period.
- **Cycles:** only single classic cycles; cti_o=000 and sel_o=all-ones always.
- **ack_i outside BUS/FLIP_BUS:** ignored.
- **Trigger during ack:** a trigger in the frame_done_o cycle counts as overrun.

## Test plan
- **First frame, mode 0:** reset, enable_i=1, zero-wait ack.
  - Trigger at cycle 100.
  - 300 writes: first adr 0000 dat F800; row 1 col 0 at adr 0020.
  - Flip write to 4000 with dat 0000.
  - frame_done_o pulses, page becomes 1.
- **Second frame, page and offset:**
  - Pixels land at base 0400 with offset 2, so pixel (0,2) ci=4 → F300.
  - Flip dat = 0800.
- **Mode 1 symmetry:** pixel (r,c) data equals pixel (r,19-c) for all r,c.
  - (0,19) = F800.
- **Timeout and retry:** slave withholds ack for the first pixel.
  - After 8 cycles, timeout_o pulses and cyc_o drops for 1 cycle.
  - Same adr 0000 is retried; ack completes the frame normally.
- **Overrun and enable:**
  - FRAME_TIME=200 with ack delayed 1 cycle: overrun_o pulses and the next frame starts on the following trigger.
  - enable_i=0 in WAIT: no bus activity across a trigger.
- **Async reset mid-BUS:** cyc_o/stb_o go low the same cycle.
  - After release, the first write is adr 0000, page 0.
